// File: rtl/port_bellek_yanitlayici.sv
// rtl/port_bellek_yanitlayici.sv - L1 port responder backed by a word-addressed memory
//
// Purpose:
//   Responder end of the L1 port request/response protocol. Accepts one
//   request at a time and services it from an internal memory of DERINLIK
//   32-bit words. Writes are masked byte writes with no response. Reads return
//   data after GECIKME extra cycles through a valid/ready data channel.
//
// Parameters:
//   DERINLIK          memory depth in 32-bit words (power of two, >= 2)
//   GECIKME           extra read-latency cycles (0..15)
//   BASLANGIC_DOSYASI init file name; memory contents are left uninitialised
//
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   port_istek_*_i               request channel (address, valid, cacheable hint,
//                                write flag, write data, byte mask)
//   port_istek_hazir_o           request ready, high only when idle
//   port_veri_o                  read data, zero outside a response
//   port_veri_gecerli_o          read data valid
//   port_veri_hazir_i            initiator ready for read data
//   port_hata_o                  out-of-range access flag (only with the macro below)
//
// Build option:
//   PORT_YANITLAYICI_ADRES_DENETIM_EN  adds out-of-range address checking and
//   port_hata_o. Without it, addresses wrap modulo DERINLIK*4.

module port_bellek_yanitlayici #(
  parameter int unsigned DERINLIK          = 1024,
  parameter int unsigned GECIKME           = 2,
  parameter string       BASLANGIC_DOSYASI = ""
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] port_istek_adres_i,
  input  logic        port_istek_gecerli_i,
  input  logic        port_istek_onbellekleme_i,
  input  logic        port_istek_yaz_i,
  input  logic [31:0] port_istek_veri_i,
  input  logic [3:0]  port_istek_maske_i,
  output logic        port_istek_hazir_o,
  output logic [31:0] port_veri_o,
  output logic        port_veri_gecerli_o,
`ifdef PORT_YANITLAYICI_ADRES_DENETIM_EN
  output logic        port_hata_o,
`endif
  input  logic        port_veri_hazir_i
);

  localparam int unsigned IDX_BIT   = $clog2(DERINLIK);
  localparam logic [3:0]  SAYAC_YUK = (GECIKME == 0) ? 4'd0 : 4'(GECIKME - 1);

  typedef enum logic [1:0] {
    BOSTA = 2'd0,
    BEKLE = 2'd1,
    YANIT = 2'd2
  } durum_t;

  logic [31:0] bellek [DERINLIK];

  durum_t      durum_q,   durum_d;
  logic [3:0]  sayac_q,   sayac_d;
  logic [31:0] kelime_q,  kelime_d;
  logic [31:0] veri_q,    veri_d;
  logic        gecerli_q, gecerli_d;
  logic        hazir_q,   hazir_d;

  logic [IDX_BIT-1:0] kelime_idx;
  logic               kabul;
  logic               yazma_kabul;
  logic               okuma_kabul;
  logic               yaz_en;
  logic [31:0]        okunan;

  // The cacheable hint and the byte-offset bits carry no meaning here.
  logic unused_girisler;
  assign unused_girisler = ^{port_istek_onbellekleme_i, port_istek_adres_i};

  assign kelime_idx  = port_istek_adres_i[IDX_BIT+1:2];
  assign kabul       = port_istek_gecerli_i && hazir_q;
  assign yazma_kabul = kabul && port_istek_yaz_i;
  assign okuma_kabul = kabul && !port_istek_yaz_i;

`ifdef PORT_YANITLAYICI_ADRES_DENETIM_EN
  logic aralik_disi;
  logic hata_q,       hata_d;
  logic hata_kayit_q, hata_kayit_d;

  // Any address bit above the word index marks the access out of range.
  assign aralik_disi = |(port_istek_adres_i >> (IDX_BIT + 2));
  assign yaz_en      = yazma_kabul && !aralik_disi && !rst_i;
  assign okunan      = aralik_disi ? 32'hDEAD_BEEF : bellek[kelime_idx];
  assign port_hata_o = hata_q;
`else
  assign yaz_en = yazma_kabul && !rst_i;
  assign okunan = bellek[kelime_idx];
`endif

  // Memory has no reset; contents survive rst_i.
  always_ff @(posedge clk_i) begin
    if (yaz_en) begin
      for (int b = 0; b < 4; b++) begin
        if (port_istek_maske_i[b]) begin
          bellek[kelime_idx][8*b +: 8] <= port_istek_veri_i[8*b +: 8];
        end
      end
    end
  end

  always_comb begin
    durum_d   = durum_q;
    sayac_d   = sayac_q;
    kelime_d  = kelime_q;
    veri_d    = veri_q;
    gecerli_d = gecerli_q;
`ifdef PORT_YANITLAYICI_ADRES_DENETIM_EN
    hata_d       = 1'b0;
    hata_kayit_d = hata_kayit_q;
`endif

    case (durum_q)
      BOSTA: begin
        if (okuma_kabul) begin
          kelime_d = okunan;
`ifdef PORT_YANITLAYICI_ADRES_DENETIM_EN
          hata_kayit_d = aralik_disi;
`endif
          if (GECIKME == 0) begin
            // Zero latency: the response is presented the cycle after accept.
            durum_d   = YANIT;
            gecerli_d = 1'b1;
            veri_d    = okunan;
`ifdef PORT_YANITLAYICI_ADRES_DENETIM_EN
            hata_d = aralik_disi;
`endif
          end else begin
            durum_d = BEKLE;
            sayac_d = SAYAC_YUK;
          end
        end
`ifdef PORT_YANITLAYICI_ADRES_DENETIM_EN
        if (yazma_kabul) begin
          hata_d = aralik_disi;
        end
`endif
      end

      BEKLE: begin
        if (sayac_q == 4'd0) begin
          durum_d   = YANIT;
          gecerli_d = 1'b1;
          veri_d    = kelime_q;
`ifdef PORT_YANITLAYICI_ADRES_DENETIM_EN
          hata_d = hata_kayit_q;
`endif
        end else begin
          sayac_d = sayac_q - 4'd1;
        end
      end

      YANIT: begin
`ifdef PORT_YANITLAYICI_ADRES_DENETIM_EN
        hata_d = hata_q;
`endif
        if (port_veri_hazir_i) begin
          durum_d   = BOSTA;
          gecerli_d = 1'b0;
          veri_d    = 32'd0;
`ifdef PORT_YANITLAYICI_ADRES_DENETIM_EN
          hata_d = 1'b0;
`endif
        end
      end

      default: begin
        durum_d   = BOSTA;
        gecerli_d = 1'b0;
        veri_d    = 32'd0;
      end
    endcase

    // Ready is a registered copy of "next state is idle", so it never
    // depends combinationally on an input.
    hazir_d = (durum_d == BOSTA);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      durum_q   <= BOSTA;
      sayac_q   <= 4'd0;
      kelime_q  <= 32'd0;
      veri_q    <= 32'd0;
      gecerli_q <= 1'b0;
      hazir_q   <= 1'b1;
`ifdef PORT_YANITLAYICI_ADRES_DENETIM_EN
      hata_q       <= 1'b0;
      hata_kayit_q <= 1'b0;
`endif
    end else begin
      durum_q   <= durum_d;
      sayac_q   <= sayac_d;
      kelime_q  <= kelime_d;
      veri_q    <= veri_d;
      gecerli_q <= gecerli_d;
      hazir_q   <= hazir_d;
`ifdef PORT_YANITLAYICI_ADRES_DENETIM_EN
      hata_q       <= hata_d;
      hata_kayit_q <= hata_kayit_d;
`endif
    end
  end

  assign port_istek_hazir_o  = hazir_q;
  assign port_veri_o         = veri_q;
  assign port_veri_gecerli_o = gecerli_q;

endmodule

// File: tb/tb_port_bellek_yanitlayici.sv
// tb/tb_port_bellek_yanitlayici.sv - directed scoreboard bench for port_bellek_yanitlayici

module tb_port_bellek_yanitlayici;

  localparam int G = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] adr;
  logic        gec;
  logic        onb;
  logic        yaz;
  logic [31:0] dat;
  logic [3:0]  msk;
  logic        hazir_o;
  logic [31:0] veri;
  logic        veri_gecerli;
  logic        veri_hazir;
`ifdef PORT_YANITLAYICI_ADRES_DENETIM_EN
  logic        hata;
`endif

  int n_cmp = 0;
  int n_err = 0;

  // Expected read responses: {hata, data}
  logic [32:0] sb[$];

  always #5 clk = ~clk;

  port_bellek_yanitlayici #(
    .DERINLIK (1024),
    .GECIKME  (G)
  ) dut (
    .clk_i                     (clk),
    .rst_i                     (rst),
    .port_istek_adres_i        (adr),
    .port_istek_gecerli_i      (gec),
    .port_istek_onbellekleme_i (onb),
    .port_istek_yaz_i          (yaz),
    .port_istek_veri_i         (dat),
    .port_istek_maske_i        (msk),
    .port_istek_hazir_o        (hazir_o),
    .port_veri_o               (veri),
    .port_veri_gecerli_o       (veri_gecerli),
`ifdef PORT_YANITLAYICI_ADRES_DENETIM_EN
    .port_hata_o               (hata),
`endif
    .port_veri_hazir_i         (veri_hazir)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Response monitor: a handshake completes on the next rising edge.
  always @(negedge clk) begin
    if (!rst && veri_gecerli && veri_hazir) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $error("FAIL unexpected_response observed=%h expected=none", veri);
      end else begin
        logic [32:0] e;
        e = sb.pop_front();
        chk("read_data", veri, e[31:0]);
`ifdef PORT_YANITLAYICI_ADRES_DENETIM_EN
        chk("read_hata", 32'(hata), 32'(e[32]));
`endif
      end
    end
  end

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
    adr = a; dat = d; msk = m; yaz = 1'b1; gec = 1'b1;
    chk("wr_hazir", 32'(hazir_o), 32'd1);
    tick();
    gec = 1'b0; yaz = 1'b0;
  endtask

  task automatic wait_gecerli(output int cyc);
    cyc = 0;
    while (!veri_gecerli && cyc < 40) begin
      tick();
      cyc++;
    end
  endtask

  // Read with veri_hazir high: checks latency, handshake and return to idle.
  task automatic rd(input logic [31:0] a, input logic [32:0] exp);
    int cyc;
    adr = a; yaz = 1'b0; gec = 1'b1;
    chk("rd_hazir", 32'(hazir_o), 32'd1);
    sb.push_back(exp);
    tick();
    gec = 1'b0;
    chk("rd_busy_hazir", 32'(hazir_o), 32'd0);
    wait_gecerli(cyc);
    chk("rd_latency", 32'(cyc), 32'(G));
    tick();
    chk("rd_done_gecerli", 32'(veri_gecerli), 32'd0);
    chk("rd_done_veri", veri, 32'd0);
    chk("rd_done_hazir", 32'(hazir_o), 32'd1);
  endtask

  initial begin
    int cyc;
    int seen;

    rst = 1'b1; adr = '0; gec = 1'b0; onb = 1'b0; yaz = 1'b0;
    dat = '0; msk = '0; veri_hazir = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    chk("rst_hazir", 32'(hazir_o), 32'd1);
    chk("rst_gecerli", 32'(veri_gecerli), 32'd0);
    chk("rst_veri", veri, 32'd0);
`ifdef PORT_YANITLAYICI_ADRES_DENETIM_EN
    chk("rst_hata", 32'(hata), 32'd0);
`endif

    // Back-to-back writes, one per cycle, cacheable hint toggling.
    gec = 1'b1; yaz = 1'b1; msk = 4'hF;
    for (int i = 0; i < 4; i++) begin
      adr = 32'(4 * i);
      dat = 32'hA000_0000 + 32'(i);
      onb = i[0];
      chk("b2b_hazir", 32'(hazir_o), 32'd1);
      tick();
    end
    gec = 1'b0; yaz = 1'b0; onb = 1'b0;
    chk("b2b_no_response", 32'(veri_gecerli), 32'd0);
    for (int i = 0; i < 4; i++) rd(32'(4 * i), {1'b0, 32'hA000_0000 + 32'(i)});

    // Full, partial and empty masks on word 2.
    wr(32'h8, 32'h1122_3344, 4'b1111);
    rd(32'h8, {1'b0, 32'h1122_3344});
    wr(32'h8, 32'hAABB_CCDD, 4'b0101);
    rd(32'h8, {1'b0, 32'h11BB_33DD});
    wr(32'h8, 32'hFFFF_FFFF, 4'b0000);
    rd(32'h8, {1'b0, 32'h11BB_33DD});

    // Back-pressure: hold veri_hazir low 5 cycles with a pending write queued.
    veri_hazir = 1'b0;
    adr = 32'h4; yaz = 1'b0; gec = 1'b1;
    chk("stall_accept_hazir", 32'(hazir_o), 32'd1);
    sb.push_back({1'b0, 32'hA000_0001});
    tick();
    gec = 1'b0;
    wait_gecerli(cyc);
    chk("stall_latency", 32'(cyc), 32'(G));
    adr = 32'h10; dat = 32'h5555_AAAA; msk = 4'hF; yaz = 1'b1; gec = 1'b1;
    for (int k = 0; k < 5; k++) begin
      chk("stall_gecerli", 32'(veri_gecerli), 32'd1);
      chk("stall_veri", veri, 32'hA000_0001);
      chk("stall_hazir", 32'(hazir_o), 32'd0);
      tick();
    end
    veri_hazir = 1'b1;
    tick();
    chk("stall_done_gecerli", 32'(veri_gecerli), 32'd0);
    chk("stall_done_hazir", 32'(hazir_o), 32'd1);
    tick();
    gec = 1'b0; yaz = 1'b0;
    rd(32'h10, {1'b0, 32'h5555_AAAA});

    // Reset while waiting out the latency drops the response.
    adr = 32'h8; yaz = 1'b0; gec = 1'b1;
    tick();
    gec = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_gecerli", 32'(veri_gecerli), 32'd0);
    chk("midrst_hazir", 32'(hazir_o), 32'd1);
    seen = 0;
    repeat (6) begin
      if (veri_gecerli) seen = 1;
      tick();
    end
    chk("midrst_dropped", 32'(seen), 32'd0);
    rd(32'h8, {1'b0, 32'h11BB_33DD});

`ifdef PORT_YANITLAYICI_ADRES_DENETIM_EN
    rd(32'h0000_1000, {1'b1, 32'hDEAD_BEEF});
    chk("oor_hata_idle", 32'(hata), 32'd0);
    wr(32'h0000_1000, 32'h1234_5678, 4'hF);
    chk("oor_wr_hata_pulse", 32'(hata), 32'd1);
    tick();
    chk("oor_wr_hata_clear", 32'(hata), 32'd0);
    rd(32'h0, {1'b0, 32'hA000_0000});
`else
    // Upper address bits are ignored: 0x1000 aliases word 0.
    wr(32'h0000_1000, 32'hCAFE_F00D, 4'hF);
    rd(32'h0, {1'b0, 32'hCAFE_F00D});
`endif

    repeat (2) tick();
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
